imm_gen_pipe: RTL
=================

# imm_gen_pipe

Registered, parametrised immediate generator for the decode stage. It accepts a 32-bit instruction through a valid/ready handshake and returns the sign-extended XLEN-bit immediate one cycle later. The immediate format comes either from an external select or from the block's own opcode decode. A two-entry skid buffer keeps full throughput under downstream back-pressure and supports a pipeline flush.

## Interface
- XLEN, 32, immediate width; legal values 32 or 64.
- USE_OPCODE, 1, 1: format decoded from i_instr[6:0]; 0: format taken from i_imm_sel.

- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_flush  in  1  synchronous flush; drops all buffered entries.
- i_valid  in  1  upstream instruction valid.
- o_ready  out  1  block can accept an instruction this cycle.
- i_instr  in  32  instruction word.
- i_imm_sel  in  3  external format select; used only when USE_OPCODE=0.
- o_valid  out  1  output entry valid.
- i_ready  in  1  downstream accepts the output entry.
- o_imm  out  XLEN  sign-extended immediate.
- o_sel  out  3  format used for o_imm.
- o_illegal  out  1  unrecognised opcode or select.

## Operation
- Format encoding:
  - 0 = I: instr[31:20].
  - 1 = I-shift: shamt = instr[24:20] for XLEN=32, instr[25:20] for XLEN=64; zero-extended.
  - 2 = S: {instr[31:25], instr[11:7]}.
  - 3 = B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - 4 = U: {instr[31:12], 12'b0}.
  - 5 = J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - 6 = reserved; immediate 0, illegal.
  - 7 = none; immediate 0, not illegal.
- Sign extension: every format except 1 sign-extends from instr[31] to XLEN. For XLEN=64, U-type bits [63:32] equal instr[31].
- Opcode decode (USE_OPCODE=1):
  - 0010011 → 1 when funct3 is 001 or 101, else 0.
  - 0000011, 1100111, 1110011 → 0.
  - 0100011 → 2.
  - 1100011 → 3.
  - 0110111, 0010111 → 4.
  - 1101111 → 5.
  - 0110011 → 7.
  - Any other opcode → 6.
- Buffering:
  - Output register (OUT) and skid register (SKID), each holding {imm, sel, illegal}.
  - The immediate is computed combinationally at the input, then registered.
  - o_ready = !skid_valid, driven directly from a register.
  - Accept = i_valid && o_ready. Retire = o_valid && i_ready.

## Timing
- Reset values: o_valid=0, o_imm=0, o_sel=0, o_illegal=0, skid_valid=0, o_ready=1.
- Latency: one cycle from accept to o_valid. Throughput is 1 per cycle while i_ready=1.
- States and transitions:
  - EMPTY: accept → FULL.
  - FULL: accept && !retire → SKID (new entry goes to SKID). accept && retire → FULL (new entry goes to OUT). retire only → EMPTY.
  - SKID: o_ready=0. Retire → FULL, with SKID moving to OUT in the same edge.
- Output hold: while o_valid && !i_ready, o_imm, o_sel and o_illegal hold stable.
- Flush: i_flush clears o_valid and skid_valid on the next edge. A concurrent accept is dropped. Flush has priority over every other event.
- Reset mid-operation: asynchronous assertion clears both entries immediately; there is no partial output.

## Configuration
- IMM_GEN_ILLEGAL_EN defined: o_illegal reports format 6 as described, and format 6 entries pass through the buffer normally.
- IMM_GEN_ILLEGAL_EN undefined: the detection logic is removed and o_illegal is tied to 0. Format 6 still yields o_imm=0.

## Test plan
- XLEN=32, i_ready=1. Send 0xFFF00093 (addi -1) → next cycle o_valid=1, o_imm=0xFFFFFFFF, o_sel=0.
- XLEN=32. Send 0xFE000EE3 (beq −4) → o_imm=0xFFFFFFFC, o_sel=3. Send 0x123450B7 (lui) → o_imm=0x12345000, o_sel=4.
- XLEN=64. Send 0x800000B7 → o_imm=0xFFFFFFFF80000000. Send 0x02109093 (slli 33) → o_imm=33, o_sel=1.
- Back-pressure: i_ready=0, three back-to-back accepts attempted → first entry in OUT, second in SKID, o_ready=0 and the third stalls. Raise i_ready → entries emerge in order on consecutive cycles, and o_ready returns to 1 one cycle after the first retire.
- Hold i_flush=1 for one cycle with the SKID state full and i_valid=1 → next cycle o_valid=0, o_ready=1, and the input is lost.
- Send 0x0000007F → o_imm=0, o_sel=6. o_illegal=1 with IMM_GEN_ILLEGAL_EN defined, 0 without it.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator for the decode stage.
// A 32-bit instruction is accepted over a valid/ready handshake. Its
// sign-extended XLEN-bit immediate appears on the output one cycle later.
// The format comes from the opcode (USE_OPCODE=1) or from i_imm_sel.
// An output register and a skid register together keep full throughput
// under back-pressure. i_flush drops both entries.
// Optional feature macro: IMM_GEN_ILLEGAL_EN. When it is defined, o_illegal
// flags the reserved format 6. When it is undefined, o_illegal is always 0.
module imm_gen_pipe #(
  parameter int unsigned XLEN       = 32,
  parameter bit          USE_OPCODE = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instr,
  input  logic [2:0]      i_imm_sel,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_imm,
  output logic [2:0]      o_sel,
  output logic            o_illegal
);

  localparam logic [2:0] SEL_I     = 3'd0;
  localparam logic [2:0] SEL_SHIFT = 3'd1;
  localparam logic [2:0] SEL_S     = 3'd2;
  localparam logic [2:0] SEL_B     = 3'd3;
  localparam logic [2:0] SEL_U     = 3'd4;
  localparam logic [2:0] SEL_J     = 3'd5;
  localparam logic [2:0] SEL_RSVD  = 3'd6;
  localparam logic [2:0] SEL_NONE  = 3'd7;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      sel;
    logic            ill;
  } entry_t;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [2:0]  dec_sel;
  logic [2:0]  sel_in;
  logic [5:0]  shamt;
  logic [31:0] imm32;
  logic [XLEN-1:0] imm_in;
  logic        ill_in;
  entry_t      entry_in;

  state_t      state_q, state_d;
  entry_t      out_q, out_d;
  entry_t      skid_q, skid_d;
  logic        out_valid_q, out_valid_d;
  logic        ready_q, ready_d;

  logic        accept;
  logic        retire;

  assign opcode = i_instr[6:0];
  assign funct3 = i_instr[14:12];

  // Decode the immediate format from the opcode.
  always_comb begin
    dec_sel = SEL_RSVD;
    case (opcode)
      7'b0010011: dec_sel = (funct3 == 3'b001 || funct3 == 3'b101) ? SEL_SHIFT : SEL_I;
      7'b0000011,
      7'b1100111,
      7'b1110011: dec_sel = SEL_I;
      7'b0100011: dec_sel = SEL_S;
      7'b1100011: dec_sel = SEL_B;
      7'b0110111,
      7'b0010111: dec_sel = SEL_U;
      7'b1101111: dec_sel = SEL_J;
      7'b0110011: dec_sel = SEL_NONE;
      default:    dec_sel = SEL_RSVD;
    endcase
  end

  assign sel_in = USE_OPCODE ? dec_sel : i_imm_sel;
  assign shamt  = (XLEN == 64) ? i_instr[25:20] : {1'b0, i_instr[24:20]};

  // Assemble the immediate. Every signed format fits in 32 bits with
  // instr[31] as its top bit, so one sign-extending cast covers both XLEN values.
  always_comb begin
    imm32  = '0;
    imm_in = '0;
    case (sel_in)
      SEL_I: imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
      SEL_S: imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      SEL_B: imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                      i_instr[30:25], i_instr[11:8], 1'b0};
      SEL_U: imm32 = {i_instr[31:12], 12'b0};
      SEL_J: imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                      i_instr[20], i_instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    if (sel_in == SEL_SHIFT) begin
      imm_in = XLEN'(shamt);
    end else begin
      imm_in = XLEN'($signed(imm32));
    end
  end

`ifdef IMM_GEN_ILLEGAL_EN
  assign ill_in = (sel_in == SEL_RSVD);
`else
  assign ill_in = 1'b0;
`endif

  assign entry_in = '{imm: imm_in, sel: sel_in, ill: ill_in};

  assign accept = i_valid && ready_q;
  assign retire = out_valid_q && i_ready;

  // Next state of the two-entry buffer. A flush overrides every other event.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (i_flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            out_d   = entry_in;
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (accept && retire) begin
            out_d = entry_in;
          end else if (accept) begin
            skid_d  = entry_in;
            state_d = ST_SKID;
          end else if (retire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          // In this state ready_q is 0, so no accept can arrive here.
          if (retire) begin
            out_d   = skid_q;
            state_d = ST_FULL;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    out_valid_d = (state_d != ST_EMPTY);
    ready_d     = (state_d != ST_SKID);
  end

  // Buffer registers. o_valid and o_ready come straight from flops.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_EMPTY;
      out_q       <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      ready_q     <= ready_d;
    end
  end

  assign o_ready   = ready_q;
  assign o_valid   = out_valid_q;
  assign o_imm     = out_q.imm;
  assign o_sel     = out_q.sel;
  assign o_illegal = out_q.ill;

endmodule
